madd_scheduler: RTL
===================

// Module: madd_scheduler
// PURPOSE
//  Shares one madd_pipeline (mul -> shift -> add -> saturate, 4 stages, in-order) between N_REQ requesters.
//  Round-robin arbitration picks one request per cycle and issues it to the pipeline. An in-order tag FIFO
//  records which requester owns each in-flight op, so each result is returned only to that requester.
//  Instantiated beside the pipeline inside the DSP engine core; requesters are block-evaluation units.
// PARAMETERS
//  data_width    16   operand width; pipeline result is 2*data_width
//  n_blocks      256  block-index range; block field width is $clog2(n_blocks)
//  N_REQ         4    number of requesters (>=2)
//  MAX_INFLIGHT  8    tag FIFO depth = credit limit on ops inside the pipeline (power of 2)
// PORTS
//  clk            in   1                single clock, rising edge
//  reset          in   1                asynchronous, active-low (0 = in reset)
//  enable         in   1                0: no grants; sequential state frozen (response drain still allowed)
//  req_valid      in   N_REQ            per-requester request valid
//  req_ready      out  N_REQ            per-requester accept (one-hot or 0)
//  req_op         in   N_REQ*OP_W       {a,b,c,shift[4:0],shift_disable,signedness,saturate_disable}
//  req_tag        in   N_REQ*TAG_W      {block,dest[3:0],commit_id[8:0],commit_flag}
//  mac_in_valid   out  1                issue valid to pipeline
//  mac_in_ready   in   1                pipeline in_ready
//  mac_op         out  OP_W             muxed op of the granted requester
//  mac_tag        out  TAG_W            muxed tag of the granted requester
//  mac_out_valid  in   1                pipeline out_valid
//  mac_out_ready  out  1                pipeline out_ready
//  mac_result     in   2*data_width     pipeline result_out
//  mac_tag_out    in   TAG_W            pipeline {block_out,dest_out,commit_id_out,commit_flag_out}
//  rsp_valid      out  N_REQ            per-requester result valid (one-hot or 0)
//  rsp_ready      in   N_REQ            per-requester result accept
//  rsp_result     out  2*data_width     mac_result, broadcast to all requesters
//  rsp_tag        out  TAG_W            mac_tag_out, broadcast to all requesters
//  inflight       out  clog2(MAX_INFLIGHT)+1   ops issued but not yet returned
//  orphan_err     out  1                sticky: a result arrived with the tag FIFO empty
// BEHAVIOUR
//  - Reset (async assert, sync release): rr_ptr=0, fifo wr/rd=0, inflight=0, orphan_err=0. Combinational outputs
//    then give req_ready=0, mac_in_valid=0, rsp_valid=0.
//  - Grant (combinational): g = first i with req_valid[i], scanning from rr_ptr upward and wrapping modulo N_REQ.
//    issue_ok = enable & (inflight<MAX_INFLIGHT) & any req_valid.
//    mac_in_valid=issue_ok; mac_op/mac_tag = req[g]; req_ready[g] = issue_ok & mac_in_ready.
//  - Issue fire (mac_in_valid & mac_in_ready): push g into the tag FIFO; rr_ptr <= (g+1) mod N_REQ; inflight++.
//    Zero added latency: request to pipeline input in the same cycle. Once valid is high, op and tag are held
//    stable until accepted.
//  - Return: h = FIFO head. If FIFO not empty: rsp_valid[h]=mac_out_valid; mac_out_ready=rsp_ready[h].
//    Fire pops the FIFO and decrements inflight. Requester h stalling back-pressures the whole pipeline.
//  - Orphan: FIFO empty & mac_out_valid -> mac_out_ready=1, result dropped, orphan_err<=1 (sticky until reset).
//  - Same-cycle issue and return: push and pop both happen; inflight unchanged. Full FIFO with a return in that
//    cycle still blocks issue (credit check uses the registered count; no bypass).
//  - enable=0: no issue, rr_ptr frozen; returns and orphan drain still proceed (pipeline is frozen anyway).
//  - Reset mid-operation: all tags are discarded; the pipeline must share the same reset event.
//  - Width: OP_W = 3*data_width+8; TAG_W = $clog2(n_blocks)+14; inflight saturates at MAX_INFLIGHT by construction.
// STRUCTURE
//  - madd_sched_pkg: OP_W/TAG_W localparams and the field offsets of the op and tag bundles
//    (shared with the evaluation units and the pipeline wrapper).
//  - Sub-module tag_fifo (depth MAX_INFLIGHT, width $clog2(N_REQ), wrap pointers plus an extra MSB
//    for full/empty).
//  - Round-robin priority mux and return routing stay inline.
// TESTING
//  - Reset: hold reset=0 with all req_valid=1 -> req_ready=0, mac_in_valid=0, inflight=0; release -> req0 granted first.
//  - Fairness: req_valid=4'b1111 for 8 issues, pipeline always ready -> grant order 0,1,2,3,0,1,2,3.
//  - Credits: MAX_INFLIGHT=8, mac_out_ready path stalled (rsp_ready=0) -> exactly 8 issues, then mac_in_valid=0
//    until one return.
//  - Routing: req1 sends a=3,b=4,c=5,shift_disable=1; req2 sends a=-2,b=7,c=0 -> rsp_valid=0010 with result 17,
//    then rsp_valid=0100 with result -14, in issue order.
//  - Back-pressure: req1 holds rsp_ready=0 for 5 cycles -> mac_out_ready=0, no FIFO pop, inflight unchanged;
//    no result is lost.
//  - Orphan: force mac_out_valid=1 with inflight=0 -> mac_out_ready=1, rsp_valid=0, orphan_err=1 until reset.

Source files
------------

// File: rtl/madd_sched_pkg.sv
// Shared widths and field offsets of the madd op/tag bundles, used by the scheduler,
// the evaluation units and the pipeline wrapper.
package madd_sched_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_N_BLOCKS = 256;

  // op bundle {a,b,c,shift[4:0],shift_disable,signedness,saturate_disable}, LSB first
  localparam int OP_SAT_DIS_BIT = 0;
  localparam int OP_SIGNED_BIT  = 1;
  localparam int OP_SH_DIS_BIT  = 2;
  localparam int OP_SHIFT_LSB   = 3;
  localparam int OP_SHIFT_W     = 5;
  localparam int OP_C_LSB       = 8;

  // tag bundle {block,dest[3:0],commit_id[8:0],commit_flag}, LSB first
  localparam int TAG_FLAG_BIT  = 0;
  localparam int TAG_CID_LSB   = 1;
  localparam int TAG_CID_W     = 9;
  localparam int TAG_DEST_LSB  = 10;
  localparam int TAG_DEST_W    = 4;
  localparam int TAG_BLOCK_LSB = 14;

  function automatic int op_width(input int dw);
    return 3 * dw + 8;
  endfunction

  function automatic int tag_width(input int nb);
    return $clog2(nb) + 14;
  endfunction

  function automatic int op_b_lsb(input int dw);
    return OP_C_LSB + dw;
  endfunction

  function automatic int op_a_lsb(input int dw);
    return OP_C_LSB + 2 * dw;
  endfunction

  localparam int OP_W  = op_width(DEF_DATA_W);
  localparam int TAG_W = tag_width(DEF_N_BLOCKS);

  typedef struct packed {
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_DATA_W-1:0] c;
    logic [OP_SHIFT_W-1:0] shift;
    logic                  shift_disable;
    logic                  signedness;
    logic                  saturate_disable;
  } madd_op_t;

  typedef struct packed {
    logic [$clog2(DEF_N_BLOCKS)-1:0] block;
    logic [TAG_DEST_W-1:0]           dest;
    logic [TAG_CID_W-1:0]            commit_id;
    logic                            commit_flag;
  } madd_tag_t;

endpackage

// File: rtl/madd_scheduler_tag_fifo.sv
// In-order owner FIFO: one requester index per op inside the pipeline.
// Wrap pointers carry an extra MSB so full and empty are distinguishable.
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/madd_scheduler.sv
// Round-robin sharing of one in-order madd pipeline between N_REQ requesters,
// with an owner FIFO routing each result back to the requester that issued it.
module madd_scheduler
  import madd_sched_pkg::*;
#(
  parameter int data_width   = 16,
  parameter int n_blocks     = 256,
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8,
  localparam int OPW = op_width(data_width),
  localparam int TGW = tag_width(n_blocks),
  localparam int IW  = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OPW-1:0]    req_op,
  input  logic [N_REQ*TGW-1:0]    req_tag,
  output logic                    mac_in_valid,
  input  logic                    mac_in_ready,
  output logic [OPW-1:0]          mac_op,
  output logic [TGW-1:0]          mac_tag,
  input  logic                    mac_out_valid,
  output logic                    mac_out_ready,
  input  logic [2*data_width-1:0] mac_result,
  input  logic [TGW-1:0]          mac_tag_out,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [2*data_width-1:0] rsp_result,
  output logic [TGW-1:0]          rsp_tag,
  output logic [IW-1:0]           inflight,
  output logic                    orphan_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] scan_idx;
  logic          found;
  logic [PW-1:0] lock_idx;
  logic          lock_vld;
  logic          any_req;
  logic          issue_ok;
  logic          issue_fire;
  logic [PW-1:0] head_idx;
  logic          fifo_empty;
  logic          ret_fire;
  logic          orphan;
  logic [IW-1:0] inflight_q;

  // A stalled offer keeps its grant so op/tag stay stable until accepted.
  always_comb begin
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[scan_idx]) begin
        grant_idx = scan_idx;
        found     = 1'b1;
      end
    end
    if (lock_vld && req_valid[lock_idx]) grant_idx = lock_idx;
  end

  assign any_req      = |req_valid;
  assign issue_ok     = reset & enable & (inflight_q < IW'(MAX_INFLIGHT)) & any_req;
  assign issue_fire   = issue_ok & mac_in_ready;
  assign mac_in_valid = issue_ok;
  assign mac_op       = req_op[int'(grant_idx)*OPW +: OPW];
  assign mac_tag      = req_tag[int'(grant_idx)*TGW +: TGW];
  assign req_ready    = issue_fire ? (N_REQ'(1) << grant_idx) : '0;

  // Return path: the FIFO head owns the result at the pipeline output.
  assign rsp_valid     = (!fifo_empty && mac_out_valid) ? (N_REQ'(1) << head_idx) : '0;
  assign mac_out_ready = fifo_empty ? 1'b1 : rsp_ready[head_idx];
  assign ret_fire      = !fifo_empty & mac_out_valid & rsp_ready[head_idx];
  assign orphan        = fifo_empty & mac_out_valid;
  assign rsp_result    = mac_result;
  assign rsp_tag       = mac_tag_out;
  assign inflight      = inflight_q;

  tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (PW)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue_fire),
    .push_data (grant_idx),
    .pop       (ret_fire),
    .pop_data  (head_idx),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (enable) begin
      if (issue_fire) rr_ptr <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      lock_vld <= issue_ok & ~mac_in_ready;
      lock_idx <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      orphan_err <= 1'b0;
    end else begin
      case ({issue_fire, ret_fire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      if (orphan) orphan_err <= 1'b1;
    end
  end

endmodule
